// File: rtl/dmem_stage_if.sv
// Request/response bundle between the LEGv8 datapath and the data-memory stage.
// master drives requests and takes responses; slave is the memory stage.
interface dmem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Address;
    logic [63:0] WriteData;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] ReadData;
    logic        resp_err;

    modport master (
        output req_valid, MemRead, MemWrite, Address, WriteData, resp_ready,
        input  req_ready, resp_valid, ReadData, resp_err
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, Address, WriteData, resp_ready,
        output req_ready, resp_valid, ReadData, resp_err
    );
endinterface

// File: rtl/dmem_stage.sv
// LDUR/STUR doubleword memory stage, one request in flight, LATENCY edges to response.
// Holds in RESP while resp_ready is low; DMEM_MISALIGN_TRAP_EN makes Address[2:0]!=0 an error.
module dmem_stage #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic         CLK,
    input  logic         resetl,
    dmem_stage_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          cap_rd, cap_wr;
    logic [63:0]   cap_addr, cap_wdat;
    logic [63:0]   rdata, rdata_nxt;
    logic          err, err_nxt;

    logic          accept, do_access;
    logic          acc_rd, acc_wr, acc_err, mem_we;
    logic [63:0]   acc_addr, acc_wdat;
    logic [IW-1:0] acc_idx;

    logic [63:0]   mem [DEPTH];

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.ReadData   = rdata;
    assign bus.resp_err   = err;

    assign accept = (state == IDLE) && bus.req_valid;

    // Live inputs only matter for LATENCY==1, where the access happens on the accept edge.
    always_comb begin
        acc_rd   = cap_rd;
        acc_wr   = cap_wr;
        acc_addr = cap_addr;
        acc_wdat = cap_wdat;
        if (state == IDLE) begin
            acc_rd   = bus.MemRead;
            acc_wr   = bus.MemWrite;
            acc_addr = bus.Address;
            acc_wdat = bus.WriteData;
        end
    end

    assign acc_idx = acc_addr[3 +: IW];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign acc_err = (|acc_addr[63:IW+3]) || (acc_rd == acc_wr) || (|acc_addr[2:0]);
`else
    logic unused_lo;
    assign unused_lo = ^acc_addr[2:0];
    assign acc_err = (|acc_addr[63:IW+3]) || (acc_rd == acc_wr);
`endif

    assign mem_we    = do_access && acc_wr && !acc_err;
    assign rdata_nxt = (acc_rd && !acc_err) ? mem[acc_idx] : 64'd0;
    assign err_nxt   = acc_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_nxt = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_rd   <= 1'b0;
            cap_wr   <= 1'b0;
            cap_addr <= '0;
            cap_wdat <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_rd   <= bus.MemRead;
                cap_wr   <= bus.MemWrite;
                cap_addr <= bus.Address;
                cap_wdat <= bus.WriteData;
            end
            if (do_access) begin
                rdata <= rdata_nxt;
                err   <= err_nxt;
            end
        end
    end

    // Array has no reset; an async reset in BUSY forces IDLE so the pending store never fires.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[acc_idx] <= acc_wdat;
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Randomized self-checking bench for dmem_stage against a word-array reference model.
module tb_dmem_stage;
    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;

    logic CLK = 1'b0;
    logic resetl;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] ref_mem [DEPTH];

    dmem_stage_if bus();

    dmem_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .CLK    (CLK),
        .resetl (resetl),
        .bus    (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic rd, input logic wr, input logic [63:0] addr);
        logic e;
        e = (addr >= 64'(DEPTH * 8)) || (rd == wr);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr[2:0] != 3'd0) e = 1'b1;
`endif
        return e;
    endfunction

    // One full transaction; junk on the request inputs while busy, optional response stall.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdat, input int hold);
        logic        exp_err;
        logic [63:0] exp_data;
        logic [63:0] d0;
        logic        e0;
        int          cyc;
        exp_err  = model_err(rd, wr, addr);
        exp_data = (rd && !exp_err) ? ref_mem[addr[7:3]] : 64'd0;

        @(negedge CLK);
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = wdat;
        @(posedge CLK);
        #1;
        bus.MemRead   = 1'($urandom);
        bus.MemWrite  = 1'($urandom);
        bus.Address   = 64'($urandom_range(0, 255));
        bus.WriteData = {$urandom, $urandom};
        cyc = 0;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(LATENCY));
        chk("resp_err", {63'd0, bus.resp_err}, {63'd0, exp_err});
        chk("read_data", bus.ReadData, exp_data);
        d0 = bus.ReadData;
        e0 = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK);
            #1;
            chk("stall_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("stall_data", bus.ReadData, d0);
            chk("stall_err", {63'd0, bus.resp_err}, {63'd0, e0});
            chk("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
        end
        @(negedge CLK);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("resp_done", {63'd0, bus.resp_valid}, 64'd0);
        bus.resp_ready = 1'b0;
        if (wr && !exp_err) ref_mem[addr[7:3]] = wdat;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r;
        logic [63:0] a;
        resetl         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = '0;
        bus.WriteData  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_read_data", bus.ReadData, 64'd0);
        chk("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        resetl = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_req(1'b1 ^ 1'b1, 1'b1, 64'(i * 8), {$urandom, $urandom}, 0);

        do_req(1'b0, 1'b1, 64'h10, 64'h9C212C90E109EF50, 0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 0);
        chk("ldur_0x10", bus.ReadData, 64'h9C212C90E109EF50);
        do_req(1'b0, 1'b1, 64'h18, 64'hAF93053C8CA68455, 0);
        do_req(1'b1, 1'b0, 64'h18, 64'h0, 0);
        chk("ldur_0x18", bus.ReadData, 64'hAF93053C8CA68455);
        do_req(1'b1, 1'b0, 64'h100, 64'h0, 0);
        do_req(1'b1, 1'b1, 64'h10, 64'h1234, 0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 0);
        do_req(1'b0, 1'b1, 64'h13, 64'h5A0E7A39, 0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 0);
        do_req(1'b0, 1'b0, 64'h28, 64'h55, 1);
        do_req(1'b1, 1'b0, 64'h18, 64'h0, 3);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 8) a = 64'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) a = 64'($urandom_range(256, 4096));
            else a = {$urandom, $urandom};
            do_req(r >= 4 && r != 9 && r != 8 ? 1'b0 : (r == 9 ? 1'b0 : 1'b1),
                   (r >= 4 && r <= 8) ? 1'b1 : 1'b0,
                   a, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        do_req(1'b0, 1'b1, 64'h10, 64'hC0FFEE0000000001, 0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 0);
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b1;
        bus.Address   = 64'h20;
        bus.WriteData = 64'h7F0C4B3F;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        chk("busy_req_ready", {63'd0, bus.req_ready}, 64'd0);
        #2;
        resetl = 1'b0;
        #1;
        chk("arst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("arst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("arst_read_data", bus.ReadData, 64'd0);
        chk("arst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        @(negedge CLK);
        resetl = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        do_req(1'b1, 1'b0, 64'h20, 64'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
